// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the fetch stage of the 5-stage pipeline.
// The package is always compiled; the counter helper is used only when FETCH_PERF_CNT_EN is defined.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    localparam word_t NOP_INSTR = 32'h0000_0000;
    localparam word_t PC_INC    = 32'd4;

    // Saturating increment used by the optional performance counters.
    function automatic word_t sat_inc(input word_t value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_stage_redirect_hold.sv
// Holds one redirect that arrives while the pipeline is stalled until fetch can apply it.
// The first captured redirect is kept; later ones are dropped until it is consumed.
module redirect_hold
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  redir_v,
    input  word_t redir_pc,
    input  logic  stall,
    input  logic  consume,
    output logic  pend_v,
    output word_t pend_pc
);

    logic  r_pend_v;
    word_t r_pend_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_v  <= 1'b0;
            r_pend_pc <= '0;
        end else if (consume) begin
            r_pend_v <= 1'b0;
        end else if (redir_v && stall && !r_pend_v) begin
            r_pend_v  <= 1'b1;
            r_pend_pc <= redir_pc;
        end
    end

    assign pend_v  = r_pend_v;
    assign pend_pc = r_pend_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID latch: owns the PC, issues icache requests, applies redirects.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt / bubble_cnt performance counters.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC0 = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        stall,
    input  logic        redir_v,
    input  logic [31:0] redir_pc,
    input  logic        halt_id,
    output logic [31:0] instr_id,
    output logic [31:0] pc4_id,
    output logic        valid_id,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    word_t r_pc;
    word_t r_instr;
    word_t r_pc4;
    logic  r_valid;

    logic  w_pend_v;
    word_t w_pend_pc;
    logic  w_fetching;
    logic  w_advance;
    logic  w_take_redir;
    logic  w_ifid_upd;
    logic  w_enter_halt;
    logic  w_load_word;
    logic  w_load_bubble;
    word_t w_target;
    word_t w_pc_plus4;

    assign w_fetching    = (r_state == FETCH);
    assign w_advance     = w_fetching && ihit && !stall;
    assign w_take_redir  = w_fetching && !stall && (redir_v || w_pend_v);
    assign w_target      = redir_v ? redir_pc : w_pend_pc;
    assign w_pc_plus4    = r_pc + PC_INC;
    assign w_ifid_upd    = w_fetching && !stall;
    // A HALT seen alongside a redirect is on the wrong path, so the redirect wins.
    assign w_enter_halt  = w_ifid_upd && halt_id && !w_take_redir;
    assign w_load_word   = w_ifid_upd && !w_take_redir && !halt_id && ihit;
    assign w_load_bubble = w_ifid_upd && !w_load_word;

    redirect_hold u_redirect_hold (
        .clk      (CLK),
        .rst      (RST),
        .redir_v  (redir_v),
        .redir_pc (redir_pc),
        .stall    (stall),
        .consume  (w_take_redir),
        .pend_v   (w_pend_v),
        .pend_pc  (w_pend_pc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        iREN         = 1'b0;
        halted       = 1'b0;
        case (r_state)
            FETCH: begin
                iREN = 1'b1;
                if (w_enter_halt) begin
                    w_state_next = HALTED;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                w_state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc <= PC0;
        end else if (w_take_redir) begin
            r_pc <= w_target;
        end else if (w_advance) begin
            r_pc <= w_pc_plus4;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (w_load_word) begin
            r_instr <= iload;
            r_pc4   <= w_pc_plus4;
            r_valid <= 1'b1;
        end else if (w_load_bubble) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end
    end

    assign iaddr    = r_pc;
    assign instr_id = r_instr;
    assign pc4_id   = r_pc4;
    assign valid_id = r_valid;

`ifdef FETCH_PERF_CNT_EN
    word_t r_fetch_cnt;
    word_t r_bubble_cnt;

    // Both gating terms already include FETCH, so the counters freeze in HALTED.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_advance) begin
                r_fetch_cnt <= sat_inc(r_fetch_cnt);
            end
            if (w_load_bubble) begin
                r_bubble_cnt <= sat_inc(r_bubble_cnt);
            end
        end
    end

    assign fetch_cnt  = r_fetch_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
